// File: rtl/rv_dmem_responder_if.sv
// Memory-stage request/response bundle plus the SRAM-side signals of the data-memory responder.
// The slave modport is the responder; the master modport is the pipeline and SRAM together.
interface rv_dmem_responder_if #(
    parameter int ADDR_W = 12
);
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       addr;
    logic [3:0]        mem_sel;
    logic [31:0]       wdata;
    logic [2:0]        funct3;
    logic              stall;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              fault;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  mem_read, mem_write, addr, mem_sel, wdata, funct3, ram_rdata,
        output stall, rdata, rvalid, fault, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output mem_read, mem_write, addr, mem_sel, wdata, funct3, ram_rdata,
        input  stall, rdata, rvalid, fault, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/rv_dmem_responder.sv
// Data-memory responder: drives a synchronous SRAM, stalls loads for the read latency and
// returns extended load data. Optional misaligned-access trap under RV_DMEM_MISALIGN_EN.
module rv_dmem_responder #(
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 1    // legal range 1..4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv_dmem_responder_if.slave   bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [1:0]  off_reg, off_next;
    logic [2:0]  f3_reg, f3_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        rvalid_reg, rvalid_next;
    logic        fault_reg, fault_next;
    logic        ram_en, stall, misaligned;
    logic [3:0]  ram_we;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = 8'(word >> {off, 3'b000});
        half_sel = 16'(word >> {off[1], 4'b0000});
        case (f3)
            3'b000:  extract = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  extract = {24'h0, byte_sel};
            3'b001:  extract = {{16{half_sel[15]}}, half_sel};
            3'b101:  extract = {16'h0, half_sel};
            default: extract = word;
        endcase
    endfunction

`ifdef RV_DMEM_MISALIGN_EN
    // funct3[1:0] encodes access size for both loads and stores (01 half, 10 word).
    assign misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                        ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        off_next    = off_reg;
        f3_next     = f3_reg;
        rdata_next  = rdata_reg;
        rvalid_next = 1'b0;
        fault_next  = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 4'b0000;
        stall       = 1'b0;
        case (state_reg)
            IDLE: begin
                // Reset gating keeps the SRAM quiet even if the pipeline presents a store.
                if (rst_n && (bus.mem_write || bus.mem_read)) begin
                    if (misaligned) begin
                        fault_next = 1'b1;
                    end else if (bus.mem_write) begin
                        ram_en = 1'b1;
                        ram_we = bus.mem_sel;
                    end else begin
                        ram_en     = 1'b1;
                        stall      = 1'b1;
                        off_next   = bus.addr[1:0];
                        f3_next    = bus.funct3;
                        cnt_next   = CNT_INIT;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg != 2'd0) begin
                    stall    = 1'b1;
                    cnt_next = cnt_reg - 2'd1;
                end else begin
                    rvalid_next = 1'b1;
                    rdata_next  = extract(bus.ram_rdata, off_reg, f3_reg);
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= 2'd0;
            off_reg    <= 2'd0;
            f3_reg     <= 3'd0;
            rdata_reg  <= 32'h0;
            rvalid_reg <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            off_reg    <= off_next;
            f3_reg     <= f3_next;
            rdata_reg  <= rdata_next;
            rvalid_reg <= rvalid_next;
            fault_reg  <= fault_next;
        end
    end

    assign bus.stall     = stall;
    assign bus.ram_en    = ram_en;
    assign bus.ram_we    = ram_we;
    assign bus.ram_addr  = bus.addr[ADDR_W+1:2];
    assign bus.ram_wdata = bus.wdata;
    assign bus.rdata     = rdata_reg;
    assign bus.rvalid    = rvalid_reg;
`ifdef RV_DMEM_MISALIGN_EN
    assign bus.fault     = fault_reg;
`else
    assign bus.fault     = 1'b0;
`endif
endmodule

// File: tb/tb_rv_dmem_responder.sv
// Directed bench: one responder with RD_LATENCY=1 and one with RD_LATENCY=3, each with its own SRAM.
module tb_rv_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        which;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [2:0]  f3;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rv_dmem_responder_if #(.ADDR_W(12)) if1 ();
    rv_dmem_responder_if #(.ADDR_W(12)) if3 ();

    rv_dmem_responder #(.ADDR_W(12), .RD_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    rv_dmem_responder #(.ADDR_W(12), .RD_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if1.mem_read  = rd & ~which;
    assign if1.mem_write = wr & ~which;
    assign if3.mem_read  = rd & which;
    assign if3.mem_write = wr & which;
    assign if1.addr = addr;   assign if3.addr = addr;
    assign if1.mem_sel = sel; assign if3.mem_sel = sel;
    assign if1.wdata = wdata; assign if3.wdata = wdata;
    assign if1.funct3 = f3;   assign if3.funct3 = f3;

    // SRAM models: latency 1 and a 3-stage read pipeline.
    logic [31:0] mem1 [0:4095];
    logic [31:0] mem3 [0:4095];
    logic [31:0] rd1, p0, p1, p2;
    always @(posedge clk) begin
        if (if1.ram_en) begin
            for (int b = 0; b < 4; b++)
                if (if1.ram_we[b]) mem1[if1.ram_addr][b*8 +: 8] <= if1.ram_wdata[b*8 +: 8];
            if (if1.ram_we == 4'b0000) rd1 <= mem1[if1.ram_addr];
        end
        if (if3.ram_en) begin
            for (int b = 0; b < 4; b++)
                if (if3.ram_we[b]) mem3[if3.ram_addr][b*8 +: 8] <= if3.ram_wdata[b*8 +: 8];
            if (if3.ram_we == 4'b0000) p0 <= mem3[if3.ram_addr];
        end
        p1 <= p0;
        p2 <= p1;
    end
    assign if1.ram_rdata = rd1;
    assign if3.ram_rdata = p2;

    logic        stall_m, rvalid_m, fault_m, ram_en_m;
    logic [31:0] rdata_m;
    logic [3:0]  ram_we_m;
    logic [11:0] ram_addr_m;
    always_comb begin
        stall_m    = which ? if3.stall    : if1.stall;
        rvalid_m   = which ? if3.rvalid   : if1.rvalid;
        fault_m    = which ? if3.fault    : if1.fault;
        ram_en_m   = which ? if3.ram_en   : if1.ram_en;
        rdata_m    = which ? if3.rdata    : if1.rdata;
        ram_we_m   = which ? if3.ram_we   : if1.ram_we;
        ram_addr_m = which ? if3.ram_addr : if1.ram_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        rd = 1'b0; wr = 1'b1; addr = a; wdata = d; sel = s; f3 = 3'b010;
        #1;
        check("store_ram_en", 32'(ram_en_m), 32'd1);
        check("store_ram_we", 32'(ram_we_m), 32'(s));
        check("store_stall", 32'(stall_m), 32'd0);
        $display("store addr=%h data=%h sel=%b", a, d, s);
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [2:0] fn);
        rd = 1'b1; wr = 1'b0; addr = a; f3 = fn;
    endtask

    // Counts stall cycles from the request cycle, then samples one cycle after stall drops.
    task automatic wait_load(output int stalls, output logic pre, output logic got,
                             output logic [31:0] data);
        stalls = 0;
        pre = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (stall_m) begin
                stalls++;
                @(posedge clk); #1;
            end else begin
                pre = rvalid_m;
                break;
            end
        end
        @(posedge clk); #1;
        got  = rvalid_m;
        data = rdata_m;
        $display("load addr=%h f3=%b stalls=%0d rvalid=%b rdata=%h", addr, f3, stalls, got, data);
    endtask

    task automatic load_check(input string tag, input logic [31:0] a, input logic [2:0] fn,
                              input int exp_stalls, input logic [31:0] exp_data);
        int          s;
        logic        pre, got;
        logic [31:0] d;
        issue(a, fn);
        wait_load(s, pre, got, d);
        rd = 1'b0;
        check({tag, "_stalls"}, 32'(s), 32'(exp_stalls));
        check({tag, "_early_valid"}, 32'(pre), 32'd0);
        check({tag, "_rvalid"}, 32'(got), 32'd1);
        check({tag, "_rdata"}, d, exp_data);
    endtask

    initial begin
        int          s1, s2, pulses;
        logic        pre1, pre2, v1, v2;
        logic [31:0] d1, d2;

        rst_n = 1'b0; which = 1'b0; rd = 1'b0; wr = 1'b1;
        addr = 32'h10; wdata = 32'h0; sel = 4'hF; f3 = 3'b010;
        #3;
        check("rst_ram_en", 32'(ram_en_m), 32'd0);
        check("rst_ram_we", 32'(ram_we_m), 32'd0);
        check("rst_stall", 32'(stall_m), 32'd0);
        check("rst_rvalid", 32'(rvalid_m), 32'd0);
        check("rst_rdata", rdata_m, 32'h0);
        check("rst_fault", 32'(fault_m), 32'd0);
        wr = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SW / LW round trip on the latency-1 responder, then a store while rvalid is high.
        store(32'h10, 32'hDEADBEEF, 4'hF);
        addr = 32'h10; #1;
        check("sw_ram_addr", 32'(ram_addr_m), 32'd4);
        issue(32'h10, 3'b010);
        wait_load(s1, pre1, v1, d1);
        rd = 1'b0;
        check("lw_stalls", 32'(s1), 32'd1);
        check("lw_early_valid", 32'(pre1), 32'd0);
        check("lw_rvalid", 32'(v1), 32'd1);
        check("lw_rdata", d1, 32'hDEADBEEF);
        store(32'h20, 32'h80FF7F01, 4'hF);
        check("lw_single_pulse", 32'(rvalid_m), 32'd0);

        // Sub-word extraction.
        load_check("lb",  32'h23, 3'b000, 1, 32'hFFFFFF80);
        load_check("lbu", 32'h23, 3'b100, 1, 32'h00000080);
        load_check("lh",  32'h22, 3'b001, 1, 32'hFFFF80FF);
        load_check("lhu", 32'h20, 3'b101, 1, 32'h00007F01);
        load_check("lb_pos", 32'h21, 3'b000, 1, 32'h0000007F);
        load_check("wrap", 32'h4010, 3'b010, 1, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("rdata_hold", rdata_m, 32'hDEADBEEF);

        // Simultaneous read and write behaves as a store.
        store(32'h30, 32'hAABBCCDD, 4'hF);
        rd = 1'b1; wr = 1'b1; addr = 32'h30; wdata = 32'h33443344; sel = 4'b0011; f3 = 3'b010;
        #1;
        check("rw_ram_en", 32'(ram_en_m), 32'd1);
        check("rw_ram_we", 32'(ram_we_m), 32'b0011);
        check("rw_stall", 32'(stall_m), 32'd0);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        check("rw_no_rvalid", 32'(rvalid_m), 32'd0);
        $display("read+write addr=30 sel=0011");
        @(posedge clk); #1;
        load_check("rw_result", 32'h30, 3'b010, 1, 32'hAABB3344);

        // Misaligned word access.
        issue(32'h21, 3'b010);
`ifdef RV_DMEM_MISALIGN_EN
        #1;
        check("mis_ram_en", 32'(ram_en_m), 32'd0);
        check("mis_stall", 32'(stall_m), 32'd0);
        @(posedge clk); #1;
        rd = 1'b0;
        check("mis_fault", 32'(fault_m), 32'd1);
        check("mis_no_rvalid", 32'(rvalid_m), 32'd0);
        @(posedge clk); #1;
        check("mis_fault_pulse", 32'(fault_m), 32'd0);
        check("mis_no_rvalid2", 32'(rvalid_m), 32'd0);
        $display("misaligned lw addr=21 trapped");
`else
        wait_load(s1, pre1, v1, d1);
        rd = 1'b0;
        check("mis_rvalid", 32'(v1), 32'd1);
        check("mis_rdata", d1, 32'h80FF7F01);
        check("mis_fault", 32'(fault_m), 32'd0);
`endif

        // Latency-3 responder: reset in the middle of WAIT drops the load.
        @(posedge clk); #1;
        which = 1'b1;
        issue(32'h10, 3'b010);
        @(posedge clk); #1;
        rst_n = 1'b0;
        rd = 1'b0;
        #1;
        check("rst_wait_stall", 32'(stall_m), 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rvalid_m) pulses++;
            if (i == 1) rst_n = 1'b1;
        end
        check("rst_wait_no_rvalid", 32'(pulses), 32'd0);
        $display("reset mid-wait pulses=%0d", pulses);
        store(32'h40, 32'hCAFEF00D, 4'hF);
        load_check("after_rst", 32'h40, 3'b010, 3, 32'hCAFEF00D);

        // Back-to-back loads at latency 3.
        store(32'h50, 32'h11111111, 4'hF);
        store(32'h54, 32'h22222222, 4'hF);
        issue(32'h50, 3'b010);
        wait_load(s1, pre1, v1, d1);
        issue(32'h54, 3'b010);
        wait_load(s2, pre2, v2, d2);
        rd = 1'b0;
        check("b2b_stalls1", 32'(s1), 32'd3);
        check("b2b_rvalid1", 32'(v1), 32'd1);
        check("b2b_rdata1", d1, 32'h11111111);
        check("b2b_stalls2", 32'(s2), 32'd3);
        check("b2b_early2", 32'(pre2), 32'd0);
        check("b2b_rvalid2", 32'(v2), 32'd1);
        check("b2b_rdata2", d2, 32'h22222222);
        @(posedge clk); #1;
        check("b2b_pulse_end", 32'(rvalid_m), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
